snitch_ssr_job_sequencer: RTL and testbench



---
 rtl/snitch_ssr_pkg.sv | 28 ++
 rtl/snitch_ssr_job_sequencer.sv | 170 +++++++++++++++++
 tb/tb_snitch_ssr_job_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snitch_ssr_pkg.sv
// Shared definitions for the SSR job sequencer.
// - Word indices of the SSR configuration register map.
// - Position of the done bit in the STATUS word.
// - ssr_job_t: the buffered descriptor. It is sized for the largest lane
//   (MaxDims), and unused dimensions stay zero.
package snitch_ssr_pkg;

  localparam int unsigned MaxDims = 4;

  localparam logic [4:0] WORD_STATUS      = 5'd0;
  localparam logic [4:0] WORD_REPEAT      = 5'd1;
  localparam logic [4:0] WORD_BOUND_BASE  = 5'd2;
  localparam logic [4:0] WORD_STRIDE_BASE = 5'd6;
  localparam logic [4:0] WORD_RPTR_BASE   = 5'd24;
  localparam logic [4:0] WORD_WPTR_BASE   = 5'd28;

  localparam int unsigned STATUS_DONE_BIT = 31;

  typedef struct packed {
    logic                      write;
    logic [1:0]                dims;
    logic [31:0]               rep;
    logic [MaxDims-1:0][31:0]  bound;
    logic [MaxDims-1:0][31:0]  stride;
    logic [31:0]               ptr;
  } ssr_job_t;

endpackage

// File: rtl/snitch_ssr_job_sequencer.sv
// Job-level controller that programs one SSR lane through its cfg word port.
// A descriptor is accepted over valid/ready. The sequencer then:
//   1. polls STATUS until the done bit is set;
//   2. writes REPEAT, BOUND(0..dims) and STRIDE(0..dims);
//   3. launches the stream by writing RPTR/WPTR(dims).
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   job_*_i/job_ready_o descriptor handshake and fields
//   cfg_*               SSR configuration port (rdata is combinational)
//   busy_o              registered "not idle"
//   jobs_o              launched-stream count (wraps)
//   err_o               sticky: a job with out-of-range dims was accepted
module snitch_ssr_job_sequencer
  import snitch_ssr_pkg::*;
#(
  parameter int unsigned NumDims  = 4,
  parameter int unsigned RptWidth = 4,
  parameter int unsigned CntWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    job_valid_i,
  output logic                    job_ready_o,
  input  logic                    job_write_i,
  input  logic [1:0]              job_dims_i,
  input  logic [RptWidth-1:0]     job_rep_i,
  input  logic [NumDims*32-1:0]   job_bound_i,
  input  logic [NumDims*32-1:0]   job_stride_i,
  input  logic [31:0]             job_ptr_i,
  output logic [4:0]              cfg_word_o,
  output logic                    cfg_write_o,
  output logic [31:0]             cfg_wdata_o,
  input  logic [31:0]             cfg_rdata_i,
  input  logic                    cfg_wready_i,
  output logic                    busy_o,
  output logic [CntWidth-1:0]     jobs_o,
  output logic                    err_o
);

  typedef enum logic [2:0] {
    IDLE, POLL, WR_REP, WR_BND, WR_STR, WR_PTR
  } seq_state_e;

  localparam logic [1:0] MaxDim = 2'(NumDims - 1);

  seq_state_e          state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  ssr_job_t            job_q, job_d;
  logic [CntWidth-1:0] jobs_q, jobs_d;
  logic                err_q, err_d;
  logic                busy_q;

  // Only the done bit of STATUS matters.
  logic unused_rdata;
  assign unused_rdata = ^cfg_rdata_i[30:0];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    job_d       = job_q;
    jobs_d      = jobs_q;
    err_d       = err_q;
    job_ready_o = 1'b0;
    cfg_word_o  = '0;
    cfg_write_o = 1'b0;
    cfg_wdata_o = '0;

    case (state_q)
      IDLE: begin
        job_ready_o = 1'b1;
        if (job_valid_i) begin
          job_d.write  = job_write_i;
          job_d.dims   = (job_dims_i > MaxDim) ? MaxDim : job_dims_i;
          job_d.rep    = 32'(job_rep_i);
          job_d.bound  = '0;
          job_d.stride = '0;
          for (int unsigned d = 0; d < NumDims; d++) begin
            job_d.bound[2'(d)]  = job_bound_i[d*32 +: 32];
            job_d.stride[2'(d)] = job_stride_i[d*32 +: 32];
          end
          job_d.ptr = job_ptr_i;
          if (job_dims_i > MaxDim) err_d = 1'b1;
          idx_d   = '0;
          state_d = POLL;
        end
      end
      POLL: begin
        cfg_word_o = WORD_STATUS;
        if (cfg_rdata_i[STATUS_DONE_BIT]) state_d = WR_REP;
      end
      WR_REP: begin
        cfg_write_o = 1'b1;
        cfg_word_o  = WORD_REPEAT;
        cfg_wdata_o = job_q.rep;
        if (cfg_wready_i) begin
          idx_d   = '0;
          state_d = WR_BND;
        end
      end
      WR_BND: begin
        cfg_write_o = 1'b1;
        cfg_word_o  = WORD_BOUND_BASE + 5'(idx_q);
        cfg_wdata_o = job_q.bound[idx_q];
        if (cfg_wready_i) begin
          if (idx_q == job_q.dims) begin
            idx_d   = '0;
            state_d = WR_STR;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      WR_STR: begin
        cfg_write_o = 1'b1;
        cfg_word_o  = WORD_STRIDE_BASE + 5'(idx_q);
        cfg_wdata_o = job_q.stride[idx_q];
        if (cfg_wready_i) begin
          if (idx_q == job_q.dims) begin
            idx_d   = '0;
            state_d = WR_PTR;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      WR_PTR: begin
        // Pointer write is the launch; count it when it completes.
        cfg_write_o = 1'b1;
        cfg_word_o  = (job_q.write ? WORD_WPTR_BASE : WORD_RPTR_BASE) + 5'(job_q.dims);
        cfg_wdata_o = job_q.ptr;
        if (cfg_wready_i) begin
          jobs_d  = jobs_q + CntWidth'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Keep the port quiet while reset is held, even before state_q is IDLE.
    if (rst_i) begin
      job_ready_o = 1'b0;
      cfg_word_o  = '0;
      cfg_write_o = 1'b0;
      cfg_wdata_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      job_q   <= '0;
      jobs_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      job_q   <= job_d;
      jobs_q  <= jobs_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign busy_o = busy_q;
  assign jobs_o = jobs_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_snitch_ssr_job_sequencer.sv
// Directed + randomized bench for snitch_ssr_job_sequencer.
// Instance A: NumDims=4, CntWidth=16. Instance B: NumDims=2, CntWidth=2.
// B is used for dims clamping, the error flag and counter wrap.
// Expected cfg writes come from a per-job list built from the word map.
module tb_snitch_ssr_job_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, job_valid, sel, job_write;
  logic [1:0]   job_dims;
  logic [3:0]   job_rep;
  logic [3:0][31:0] job_bound, job_stride;
  logic [31:0]  job_ptr, cfg_rdata;
  logic         cfg_wready;

  logic a_ready, a_write, a_busy, a_err;
  logic [4:0] a_word;
  logic [31:0] a_wdata;
  logic [15:0] a_jobs;
  logic b_ready, b_write, b_busy, b_err;
  logic [4:0] b_word;
  logic [31:0] b_wdata;
  logic [1:0] b_jobs;

  snitch_ssr_job_sequencer #(.NumDims(4), .RptWidth(4), .CntWidth(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .job_valid_i(job_valid & ~sel), .job_ready_o(a_ready),
    .job_write_i(job_write), .job_dims_i(job_dims), .job_rep_i(job_rep),
    .job_bound_i(job_bound), .job_stride_i(job_stride), .job_ptr_i(job_ptr),
    .cfg_word_o(a_word), .cfg_write_o(a_write), .cfg_wdata_o(a_wdata),
    .cfg_rdata_i(cfg_rdata), .cfg_wready_i(cfg_wready), .busy_o(a_busy),
    .jobs_o(a_jobs), .err_o(a_err));

  snitch_ssr_job_sequencer #(.NumDims(2), .RptWidth(4), .CntWidth(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .job_valid_i(job_valid & sel), .job_ready_o(b_ready),
    .job_write_i(job_write), .job_dims_i(job_dims), .job_rep_i(job_rep),
    .job_bound_i(job_bound[1:0]), .job_stride_i(job_stride[1:0]), .job_ptr_i(job_ptr),
    .cfg_word_o(b_word), .cfg_write_o(b_write), .cfg_wdata_o(b_wdata),
    .cfg_rdata_i(cfg_rdata), .cfg_wready_i(cfg_wready), .busy_o(b_busy),
    .jobs_o(b_jobs), .err_o(b_err));

  wire        o_ready = sel ? b_ready : a_ready;
  wire        o_write = sel ? b_write : a_write;
  wire        o_busy  = sel ? b_busy  : a_busy;
  wire        o_err   = sel ? b_err   : a_err;
  wire [4:0]  o_word  = sel ? b_word  : a_word;
  wire [31:0] o_wdata = sel ? b_wdata : a_wdata;
  wire [15:0] o_jobs  = sel ? {14'd0, b_jobs} : a_jobs;

  int n_chk = 0, n_fail = 0;
  int jobs_a = 0, jobs_b = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] jobs_exp();
    return sel ? 16'(jobs_b % 4) : 16'(jobs_a % 65536);
  endfunction

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, o_ready, 1);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_write"}, o_write, 0);
    chk({tag, "_word"},  o_word, 0);
    chk({tag, "_wdata"}, o_wdata, 0);
    chk({tag, "_jobs"},  o_jobs, jobs_exp());
    tick();
  endtask

  // bp: 0 = always ready, 1 = toggling, 2 = random. abort_at > 0 returns
  // after that many completed writes, leaving the job in flight.
  task automatic run_job(input bit sel_b, input bit wr, input logic [1:0] dims,
                         input logic [3:0] rep, input logic [3:0][31:0] bnd,
                         input logic [3:0][31:0] str, input logic [31:0] ptr,
                         input int poll_wait, input int bp, input int abort_at,
                         output int waited);
    logic [36:0] q[$];
    int nd, de, npoll, nwr;
    bit polling, done;
    sel = sel_b; job_write = wr; job_dims = dims; job_rep = rep;
    job_bound = bnd; job_stride = str; job_ptr = ptr; job_valid = 1'b1;
    nd = sel_b ? 2 : 4;
    de = (int'(dims) > nd - 1) ? nd - 1 : int'(dims);
    q.push_back({5'd1, 32'(rep)});
    for (int d = 0; d <= de; d++) q.push_back({5'(2 + d), bnd[d]});
    for (int d = 0; d <= de; d++) q.push_back({5'(6 + d), str[d]});
    q.push_back({5'((wr ? 28 : 24) + de), ptr});
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (o_ready) break;
      waited++;
      if (waited > 40) begin
        chk("accept_timeout", 0, 1);
        job_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("busy_at_accept", o_busy, 0);
    chk("jobs_at_accept", o_jobs, jobs_exp());
    tick();
    // Descriptor may change right after the handshake.
    job_valid = 1'b0; job_rep = 4'($urandom); job_ptr = $urandom;
    job_dims = 2'($urandom);
    for (int d = 0; d < 4; d++) begin
      job_bound[d] = $urandom;
      job_stride[d] = $urandom;
    end
    polling = 1; npoll = 0; nwr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      done = polling ? (npoll == poll_wait) : 1'($urandom);
      cfg_rdata = {done, 31'($urandom)};
      case (bp)
        0: cfg_wready = 1'b1;
        1: cfg_wready = cyc[0];
        default: cfg_wready = 1'($urandom);
      endcase
      @(negedge clk);
      chk("busy", o_busy, 1);
      if (polling) begin
        chk("poll_write", o_write, 0);
        chk("poll_word", o_word, 0);
        npoll++;
        if (done) polling = 0;
      end else begin
        chk("wr_valid", o_write, 1);
        chk("wr_word", o_word, q[0][36:32]);
        chk("wr_data", o_wdata, q[0][31:0]);
        if (cfg_wready) begin
          void'(q.pop_front());
          nwr++;
          if (q.size() == 0) begin
            chk("ready_at_launch", o_ready, 0);
            if (sel_b) jobs_b++; else jobs_a++;
            tick();
            return;
          end
          if (nwr == abort_at) begin
            tick();
            return;
          end
        end
      end
      tick();
    end
    chk("job_timeout", 0, 1);
  endtask

  logic [3:0][31:0] bnd, str;
  int w, w2;

  task automatic rand_desc();
    for (int d = 0; d < 4; d++) begin
      bnd[d] = $urandom;
      str[d] = $urandom;
    end
  endtask

  initial begin
    rst = 1'b1; job_valid = 0; sel = 0; job_write = 0; job_dims = 0; job_rep = 0;
    job_bound = '0; job_stride = '0; job_ptr = 0; cfg_rdata = 0; cfg_wready = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready_a", a_ready, 0);
      chk("rst_ready_b", b_ready, 0);
      chk("rst_write", a_write, 0);
      chk("rst_word", a_word, 0);
      chk("rst_wdata", a_wdata, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_jobs", a_jobs, 0);
      chk("rst_err", a_err, 0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", a_ready, 1);
    tick();

    // 2-dim read job from the descriptor in the block description.
    bnd = '0; str = '0;
    bnd[0] = 7; bnd[1] = 3; str[0] = 8; str[1] = 64;
    run_job(0, 0, 2'd1, 4'd3, bnd, str, 32'h1000, 0, 0, -1, w);
    idle_check("job1");

    // Poll stall: done low for 5 cycles.
    rand_desc();
    run_job(0, 0, 2'd2, 4'($urandom), bnd, str, $urandom, 5, 0, -1, w);
    idle_check("pollstall");

    // 4-dim write job under toggling backpressure; launch lands on word 31.
    rand_desc();
    run_job(0, 1, 2'd3, 4'($urandom), bnd, str, $urandom, 1, 1, -1, w);
    idle_check("bp4");

    // Back-to-back: second job accepted the cycle after the launch.
    rand_desc();
    run_job(0, 1, 2'd0, 4'($urandom), bnd, str, $urandom, 0, 0, -1, w);
    rand_desc();
    run_job(0, 0, 2'd1, 4'($urandom), bnd, str, $urandom, 0, 0, -1, w2);
    chk("b2b_gap", w2, 0);
    idle_check("b2b");

    // Randomized jobs.
    for (int k = 0; k < 6; k++) begin
      rand_desc();
      run_job(0, 1'($urandom), 2'($urandom), 4'($urandom), bnd, str, $urandom,
              $urandom_range(0, 3), 2, -1, w);
      idle_check("rand");
    end
    chk("a_err_legal", a_err, 0);

    // Instance B: dims=3 is illegal there; runs clamped to 2 dims.
    sel = 1'b1;
    chk("b_err_before", b_err, 0);
    rand_desc();
    run_job(1, 0, 2'd3, 4'($urandom), bnd, str, 32'hCAFE_0000, 0, 0, -1, w);
    idle_check("illegal");
    chk("b_err_set", b_err, 1);
    for (int k = 0; k < 4; k++) begin
      rand_desc();
      run_job(1, 1'($urandom), 2'($urandom_range(0, 1)), 4'($urandom), bnd, str,
              $urandom, 0, 2, -1, w);
      idle_check("wrap");
    end
    chk("b_err_sticky", b_err, 1);

    // Reset while in WR_STR of a 2-dim job on A.
    rand_desc();
    run_job(0, 0, 2'd1, 4'($urandom), bnd, str, $urandom, 0, 0, 4, w);
    cfg_wready = 1'b0;
    @(negedge clk);
    chk("pre_rst_word", a_word, 7);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("in_rst_ready", a_ready, 0);
    chk("in_rst_write", a_write, 0);
    tick();
    rst = 1'b0;
    jobs_a = 0; jobs_b = 0;
    @(negedge clk);
    chk("mid_rst_write", a_write, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_jobs", a_jobs, 0);
    chk("mid_rst_ready", a_ready, 1);
    chk("mid_rst_err_b", b_err, 0);
    tick();

    rand_desc();
    run_job(0, 1, 2'd2, 4'($urandom), bnd, str, $urandom, 2, 2, -1, w);
    idle_check("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
